// File: rtl/run_sequencer.sv
// Sequences one CPU program run: req/done handshake, core reset hold, run enable and halt detection.
// Optional watchdog on run length is enabled with RUN_SEQUENCER_WATCHDOG_EN.
module run_sequencer #(
    parameter int unsigned D         = 10,
    parameter int unsigned HALT_ADDR = 128,
    parameter int unsigned RST_CYC   = 2,
    parameter int unsigned C         = 16,
    parameter int unsigned WDOG_MAX  = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [D-1:0] prog_ctr,
    output logic         core_reset,
    output logic         core_run,
    output logic         busy,
    output logic         done,
    output logic [C-1:0] cycle_cnt,
    output logic         timeout
);

    localparam int unsigned RCW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Reject parameter values the reset counter or cycle counter cannot represent
    if (RST_CYC < 1 || RST_CYC > 15) begin : g_bad_rst_cyc
        $error("run_sequencer: RST_CYC must be in 1..15");
    end
    if (WDOG_MAX < 1 || WDOG_MAX > ((1 << C) - 1)) begin : g_bad_wdog_max
        $error("run_sequencer: WDOG_MAX must be in 1..2**C-1");
    end

    state_t         state_q, state_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [C-1:0]   cycle_cnt_d;
    logic           busy_d, done_d, core_reset_d, core_run_d;
    logic           halt_c;

`ifdef RUN_SEQUENCER_WATCHDOG_EN
    logic timeout_d;
    logic wdog_hit_c;

    assign wdog_hit_c = (cycle_cnt >= C'(WDOG_MAX));
`endif

    assign halt_c = (prog_ctr == D'(HALT_ADDR));

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt;
        busy_d      = busy;
        done_d      = done;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
        timeout_d   = timeout;
`endif

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d     = S_RST;
                    rst_cnt_d   = RCW'(RST_CYC - 1);
                    cycle_cnt_d = '0;
                    busy_d      = 1'b1;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
                    timeout_d   = 1'b0;
`endif
                end
            end
            S_RST: begin
                if (rst_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RCW'(1);
                end
            end
            S_RUN: begin
                if (halt_c) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
                end else if (wdog_hit_c) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
`endif
                end else if (cycle_cnt != {C{1'b1}}) begin
                    cycle_cnt_d = cycle_cnt + C'(1);
                end
            end
            S_DONE: begin
                if (!req) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Core controls follow the state being entered so they line up with it
        core_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
        core_run_d   = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rst_cnt_q  <= '0;
            cycle_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_reset <= 1'b1;
            core_run   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            cycle_cnt  <= cycle_cnt_d;
            busy       <= busy_d;
            done       <= done_d;
            core_reset <= core_reset_d;
            core_run   <= core_run_d;
        end
    end

`ifdef RUN_SEQUENCER_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: vector table, directed run sequences and randomized
// stimulus checked against a cycle-count based reference model.
module tb_run_sequencer;

    localparam int unsigned D     = 10;
    localparam int unsigned HALT  = 128;
    localparam int unsigned RSTC  = 2;
    localparam int unsigned C     = 16;
    localparam int unsigned WDOG  = 64;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic [D-1:0] prog_ctr;
    logic         core_reset, core_run, busy, done, timeout;
    logic [C-1:0] cycle_cnt;

    run_sequencer #(
        .D(D), .HALT_ADDR(HALT), .RST_CYC(RSTC), .C(C), .WDOG_MAX(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(prog_ctr),
        .core_reset(core_reset), .core_run(core_run), .busy(busy),
        .done(done), .cycle_cnt(cycle_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a run is tracked by cycles since acceptance and a run-cycle count
    bit m_active = 0, m_done = 0, m_to = 0;
    int m_since  = 0;
    int m_cnt    = 0;
    bit e_cr = 1, e_run = 0, e_busy = 0, e_done = 0, e_to = 0;
    int e_cnt = 0;
    logic [D-1:0] bpc = '0;

    function automatic void model_update(input bit r, input bit q, input logic [D-1:0] pc);
        if (r) begin
            m_active = 0; m_done = 0; m_cnt = 0; m_to = 0;
        end else if (m_done) begin
            if (!q) m_done = 0;
        end else if (m_active) begin
            if (m_since < int'(RSTC)) m_since++;
            else if (pc == D'(HALT)) begin m_active = 0; m_done = 1; end
            else if (WDOG_ON && m_cnt >= int'(WDOG)) begin m_active = 0; m_done = 1; m_to = 1; end
            else if (m_cnt < (1 << C) - 1) m_cnt++;
        end else if (q) begin
            m_active = 1; m_since = 0; m_cnt = 0; m_to = 0;
        end
        e_run  = m_active && (m_since >= int'(RSTC));
        e_cr   = !m_done && !e_run;
        e_busy = m_active;
        e_done = m_done;
        e_cnt  = m_cnt;
        e_to   = m_to;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, advance model with the sampled inputs, compare every output
    task automatic step(input bit r, input bit q, input bit use_bpc, input logic [D-1:0] pc_in);
        logic [D-1:0] pc;
        bit pre_cr, pre_run;
        pc = use_bpc ? bpc : pc_in;
        reset = r; req = q; prog_ctr = pc;
        pre_cr = e_cr; pre_run = e_run;
        @(posedge clk);
        model_update(r, q, pc);
        bpc = pre_cr ? '0 : (pre_run ? bpc + D'(1) : bpc);
        #1;
        chk("core_reset", 32'(core_reset), 32'(e_cr));
        chk("core_run",   32'(core_run),   32'(e_run));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("done",       32'(done),       32'(e_done));
        chk("cycle_cnt",  32'(cycle_cnt),  32'(e_cnt));
        chk("timeout",    32'(timeout),    32'(e_to));
    endtask

    task automatic pstep(input bit r, input bit q);
        step(r, q, 1'b1, '0);
    endtask

    typedef struct {
        bit r; bit q; logic [D-1:0] pc;
        bit cr; bit run; bit bz; bit dn; int cnt;
    } vec_t;

    vec_t tbl[21];

    initial begin
        reset = 1'b1; req = 1'b0; prog_ctr = '0;

        tbl[0]  = '{1, 0, 10'd0,   1, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 10'd0,   1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 10'd0,   1, 0, 1, 0, 0};
        tbl[3]  = '{0, 1, 10'd0,   1, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 10'd0,   0, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 10'd0,   0, 1, 1, 0, 1};
        tbl[6]  = '{0, 0, 10'h280, 0, 1, 1, 0, 2};
        tbl[7]  = '{0, 0, 10'd128, 0, 0, 0, 1, 2};
        tbl[8]  = '{0, 0, 10'd0,   1, 0, 0, 0, 2};
        tbl[9]  = '{0, 0, 10'd128, 1, 0, 0, 0, 2};
        tbl[10] = '{0, 1, 10'd128, 1, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 10'd128, 1, 0, 1, 0, 0};
        tbl[12] = '{0, 1, 10'd128, 0, 1, 1, 0, 0};
        tbl[13] = '{0, 1, 10'd128, 0, 0, 0, 1, 0};
        tbl[14] = '{0, 1, 10'd0,   0, 0, 0, 1, 0};
        tbl[15] = '{0, 1, 10'd0,   0, 0, 0, 1, 0};
        tbl[16] = '{0, 0, 10'd0,   1, 0, 0, 0, 0};
        tbl[17] = '{0, 1, 10'd0,   1, 0, 1, 0, 0};
        tbl[18] = '{1, 1, 10'd0,   1, 0, 0, 0, 0};
        tbl[19] = '{0, 0, 10'd0,   1, 0, 0, 0, 0};
        tbl[20] = '{0, 0, 10'd0,   1, 0, 0, 0, 0};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].q, 1'b0, tbl[i].pc);
            chk($sformatf("tbl%0d.core_reset", i), 32'(core_reset), 32'(tbl[i].cr));
            chk($sformatf("tbl%0d.core_run", i),   32'(core_run),   32'(tbl[i].run));
            chk($sformatf("tbl%0d.busy", i),       32'(busy),       32'(tbl[i].bz));
            chk($sformatf("tbl%0d.done", i),       32'(done),       32'(tbl[i].dn));
            chk($sformatf("tbl%0d.cycle_cnt", i),  32'(cycle_cnt),  32'(tbl[i].cnt));
        end

        // Full run with a counting PC, req held through done
        pstep(1, 0); pstep(1, 0);
        pstep(0, 1); chk("A.rst1", 32'(core_reset), 32'd1);
        pstep(0, 1); chk("A.rst2", 32'(core_reset), 32'd1);
        pstep(0, 1); chk("A.run", 32'(core_run), 32'd1); chk("A.busy", 32'(busy), 32'd1);
        for (int i = 0; i < 300 && !e_done; i++) pstep(0, 1);
        chk("A.done", 32'(done), 32'd1);
        chk("A.cnt", 32'(cycle_cnt), 32'd128);
        chk("A.busy_off", 32'(busy), 32'd0);
        chk("A.frozen", 32'(core_run), 32'd0);
        for (int i = 0; i < 5; i++) begin
            pstep(0, 1); chk("A.hold_done", 32'(done), 32'd1);
        end
        pstep(0, 0); chk("A.done_clr", 32'(done), 32'd0); chk("A.cnt_keep", 32'(cycle_cnt), 32'd128);
        pstep(0, 0); chk("A.no_restart", 32'(busy), 32'd0);

        // req dropped mid-run: run completes, done clears right after
        pstep(0, 1);
        for (int i = 0; i < 100 && e_cnt < 40; i++) pstep(0, 1);
        chk("B.cnt40", 32'(cycle_cnt), 32'd40);
        for (int i = 0; i < 300 && !e_done; i++) pstep(0, 0);
        chk("B.done", 32'(done), 32'd1);
        chk("B.cnt", 32'(cycle_cnt), 32'd128);
        pstep(0, 0); chk("B.done_clr", 32'(done), 32'd0);

        // reset mid-run abandons the run
        pstep(0, 1);
        for (int i = 0; i < 100 && e_cnt < 50; i++) pstep(0, 1);
        pstep(1, 1);
        chk("C.core_reset", 32'(core_reset), 32'd1);
        chk("C.cnt0", 32'(cycle_cnt), 32'd0);
        chk("C.busy0", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            pstep(0, 0); chk("C.no_done", 32'(done), 32'd0);
        end
        for (int i = 0; i < 300 && !e_done; i++) pstep(0, 1);
        chk("C.fresh_done", 32'(done), 32'd1);
        chk("C.fresh_cnt", 32'(cycle_cnt), 32'd128);
        pstep(0, 0);

`ifdef RUN_SEQUENCER_WATCHDOG_EN
        // PC stuck below the halt address: watchdog ends the run
        for (int i = 0; i < 200 && !e_done; i++) step(0, 1, 1'b0, 10'd5);
        chk("D.timeout", 32'(timeout), 32'd1);
        chk("D.cnt", 32'(cycle_cnt), 32'd64);
        step(0, 0, 1'b0, 10'd5);
        step(0, 1, 1'b0, 10'd5);
        chk("D.timeout_clr", 32'(timeout), 32'd0);
        step(1, 0, 1'b0, 10'd5);
`endif

        // Randomized traffic against the model
        begin
            bit q = 0;
            for (int i = 0; i < 3000; i++) begin
                bit r;
                logic [D-1:0] pc;
                r = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 7) == 0) q = ~q;
                pc = ($urandom_range(0, 11) == 0) ? D'(HALT) : D'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) == 0) step(r, q, 1'b1, '0);
                else step(r, q, 1'b0, pc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Sequences one program run of the CPU core between the external req/done handshake and the core's reset and run-enable inputs.
- On a request, it holds the core in reset for a fixed number of cycles, then lets it run.
- While the core runs, it watches the program counter for the halt address, counts execution cycles and raises done.
- Sits between the top-level ports and the fetch subassembly: it drives the reset and run-enable of the PC and flag registers, and replaces the bare prog_ctr comparison for done.

Parameters:
- D, 10, program counter width.
- HALT_ADDR, 128, program counter value that ends a run (D bits).
- RST_CYC, 2, number of cycles the core is held in reset before running; legal range 1..15.
- C, 16, cycle counter width.
- WDOG_MAX, 4096, watchdog limit in run cycles; used only with RUN_SEQUENCER_WATCHDOG_EN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high block reset.
- req  input  1  run request from the testbench or host; level-sensitive.
- prog_ctr  input  D  current program counter from the PC.
- core_reset  output  1  synchronous reset to PC, flag registers and register file.
- core_run  output  1  run enable for the PC and state writes; 0 freezes the core.
- busy  output  1  high from request acceptance until done is asserted.
- done  output  1  run complete; held until req falls.
- cycle_cnt  output  C  number of RUN cycles in the current or last run.
- timeout  output  1  run ended by the watchdog; 0 when the feature is compiled out.

Behaviour:
- Reset: this is the only reset; it is synchronous and active-high, sampled on the rising edge of clk.
  - State IDLE.
  - core_reset=1, core_run=0, busy=0, done=0, cycle_cnt=0, timeout=0.
- All outputs are registered: each one changes the cycle after the state or condition that causes it.
- States and transitions: IDLE, RST, RUN, DONE.
- IDLE:
  - core_reset=1, core_run=0.
  - If req=1: go to RST, load the reset counter with RST_CYC-1, clear cycle_cnt and timeout, set busy=1.
- RST:
  - core_reset=1, core_run=0; the reset counter decrements each cycle.
  - When the counter reaches 0, go to RUN. core_reset is therefore high for exactly RST_CYC cycles after IDLE.
- RUN:
  - core_reset=0, core_run=1.
  - cycle_cnt increments by 1 each cycle and saturates at all-ones; it never wraps.
  - If prog_ctr==HALT_ADDR: go to DONE. The compare is full D-bit equality.
  - The cycle in which the halt is seen is not counted.
- DONE:
  - core_run=0, core_reset=0, so the core state stays frozen for inspection.
  - done=1, busy=0; cycle_cnt is held.
  - If req=0: go to IDLE and clear done; cycle_cnt holds its value until the next accepted request.
- req falling during RST or RUN: ignored; the run completes, and DONE is left on the first cycle req=0 is seen.
- req held high through DONE: no restart; a new run needs req to fall and then rise again, i.e. at least one IDLE cycle.
- prog_ctr==HALT_ADDR during RST or IDLE: ignored.
- reset asserted in any state: the next cycle is IDLE with reset values; an in-progress run is abandoned and no done pulse is produced.
- reset and req high together: reset wins; req is sampled again from the following cycle.

Optional Feature:
- Macro: RUN_SEQUENCER_WATCHDOG_EN.
- Defined:
  - In RUN, if cycle_cnt reaches WDOG_MAX before the halt address is seen, go to DONE with timeout=1.
  - timeout stays set until the next accepted request.
  - If the halt address and the limit occur in the same cycle, the halt wins and timeout=0.
- Undefined:
  - No watchdog logic; timeout is tied to 0.
  - A run without a halt stays in RUN indefinitely, with cycle_cnt saturated.

Test Plan:
- reset high for 2 cycles, then req=1 with RST_CYC=2 -> core_reset high for 2 cycles after IDLE, then core_run=1 and busy=1.
- Model PC counting from 0 in RUN, reaching 128 on its 129th run cycle -> done=1, busy=0, core_run=0, cycle_cnt=128.
- Hold req=1 for 5 cycles after done, then drop it -> done drops the cycle after req=0 is seen; no second run starts; cycle_cnt stays 128.
- Drop req in the middle of RUN at cycle_cnt=40 -> the run continues to the halt address; done asserts, then clears one cycle later because req is already 0.
- Assert reset at cycle_cnt=50 -> next cycle is IDLE, core_reset=1, cycle_cnt=0, done never asserts; a fresh req then runs normally.
- With RUN_SEQUENCER_WATCHDOG_EN and WDOG_MAX=64, PC stuck at 5 -> DONE reached with timeout=1, cycle_cnt=64; the next req clears timeout.
